// File: rtl/nanosoc_ahb_pkg.sv
// AHB transfer/burst encodings and arbitration mode constants shared by the
// nanosoc bus-matrix output-stage arbiter.
package nanosoc_ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Beats still to come after the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] burst_beats_left(input logic [2:0] hburst);
    logic [3:0] beats;
    beats = 4'd0;
    case (hburst)
      BURST_WRAP16, BURST_INCR16: beats = 4'd15;
      BURST_WRAP8,  BURST_INCR8:  beats = 4'd7;
      BURST_WRAP4,  BURST_INCR4:  beats = 4'd3;
      default:                    beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/nanosoc_arb_burst_tracker.sv
// Tracks the granted port's fixed-length burst so the arbiter can hold the
// grant, and forces the hold off after too many early-terminated bursts.
module nanosoc_arb_burst_tracker
  import nanosoc_ahb_pkg::*;
#(
  parameter int EARLY_TERM_MAX = 2
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  output logic       next_hold,
  output logic       early_term_force_next
);

  localparam logic [1:0] ET_MAX = 2'(EARLY_TERM_MAX);

  logic [3:0] count_p0, count_nxt;
  logic       hold_p0;
  logic [1:0] et_cnt_p0, et_cnt_nxt;

  always_comb begin
    count_nxt             = count_p0;
    next_hold             = hold_p0;
    early_term_force_next = 1'b0;
    et_cnt_nxt            = et_cnt_p0;

    if (!HSELM) begin
      count_nxt = 4'd0;
      next_hold = 1'b0;
    end else begin
      case (HTRANSM)
        TRANS_NONSEQ: begin
          count_nxt = burst_beats_left(HBURSTM);
          next_hold = (count_nxt != 4'd0);
        end
        TRANS_SEQ: begin
          count_nxt = count_p0 - 4'd1;
          if (count_p0 == 4'd1) next_hold = 1'b0;
        end
        TRANS_BUSY: begin
          count_nxt = count_p0;
          next_hold = hold_p0;
        end
        default: begin
          count_nxt = 4'd0;
          next_hold = 1'b0;
        end
      endcase
    end

    // A new NONSEQ after the tolerated number of early terminations releases the slave.
    if ((et_cnt_p0 == ET_MAX) && (HTRANSM == TRANS_NONSEQ)) begin
      next_hold             = 1'b0;
      count_nxt             = 4'd0;
      early_term_force_next = 1'b1;
    end

    if (!next_hold) begin
      et_cnt_nxt = 2'd0;
    end else if (hold_p0 && (HTRANSM == TRANS_NONSEQ)) begin
      et_cnt_nxt = et_cnt_p0 + 2'd1;
    end
  end

  // Stage p0: burst state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      count_p0  <= 4'd0;
      hold_p0   <= 1'b0;
      et_cnt_p0 <= 2'd0;
    end else if (HREADYM) begin
      count_p0  <= count_nxt;
      hold_p0   <= next_hold;
      et_cnt_p0 <= et_cnt_nxt;
    end
  end

endmodule

// File: rtl/nanosoc_arbiter_param.sv
// Output-stage arbiter for one nanosoc bus-matrix slave: fixed-priority or
// round-robin selection with burst/lock hold and early-termination bounding.
module nanosoc_arbiter_param
  import nanosoc_ahb_pkg::*;
#(
  parameter  int NUM_PORTS      = 4,
  parameter  int ARB_MODE       = ARB_FIXED,
  parameter  int EARLY_TERM_MAX = 2,
  localparam int PORT_W         = $clog2(NUM_PORTS)
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic                 early_term_force
);

  localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

  logic                 next_hold;
  logic                 early_term_force_next;
  logic [PORT_W-1:0]    rr_ptr;
  logic [NUM_PORTS-1:0] cur_onehot, cand;
  logic [PORT_W-1:0]    pick, addr_nxt, rr_nxt;
  logic                 pick_vld, no_port_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;

  nanosoc_arb_burst_tracker #(
    .EARLY_TERM_MAX(EARLY_TERM_MAX)
  ) u_burst_tracker (
    .HCLK                  (HCLK),
    .HRESET                (HRESET),
    .HREADYM               (HREADYM),
    .HSELM                 (HSELM),
    .HTRANSM               (HTRANSM),
    .HBURSTM               (HBURSTM),
    .next_hold             (next_hold),
    .early_term_force_next (early_term_force_next)
  );

  always_comb begin
    cur_onehot = ONE << addr_in_port;
    // The current owner stays a candidate while it is still mid-transaction.
    cand = req_port | (cur_onehot & {NUM_PORTS{HSELM && (HTRANSM != TRANS_IDLE)}});

    pick     = addr_in_port;
    pick_vld = 1'b0;
    if (ARB_MODE == ARB_RR) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!pick_vld && cand[PORT_W'((int'(rr_ptr) + k) % NUM_PORTS)]) begin
          pick     = PORT_W'((int'(rr_ptr) + k) % NUM_PORTS);
          pick_vld = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (cand[PORT_W'(i)]) begin
          pick     = PORT_W'(i);
          pick_vld = 1'b1;
        end
      end
    end

    addr_nxt    = addr_in_port;
    rr_nxt      = rr_ptr;
    no_port_nxt = 1'b0;
    if (HMASTLOCKM || next_hold) begin
      no_port_nxt = 1'b0;
    end else if (pick_vld) begin
      addr_nxt = pick;
      rr_nxt   = pick;
    end else if (!HSELM) begin
      no_port_nxt = 1'b1;
    end

    grant_nxt = no_port_nxt ? '0 : (ONE << addr_nxt);
  end

  // Stage p0: grant registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_in_port     <= '0;
      no_port          <= 1'b1;
      grant_onehot     <= '0;
      early_term_force <= 1'b0;
      rr_ptr           <= PORT_W'(NUM_PORTS - 1);
    end else if (HREADYM) begin
      addr_in_port     <= addr_nxt;
      no_port          <= no_port_nxt;
      grant_onehot     <= grant_nxt;
      early_term_force <= early_term_force_next;
      rr_ptr           <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_nanosoc_arbiter_param.sv
// Bench for nanosoc_arbiter_param: fixed and round-robin instances on shared
// stimulus, compared each cycle against a beat-counting behavioural model.
module tb_nanosoc_arbiter_param;

  localparam int N   = 4;
  localparam int ETM = 2;

  logic       HCLK = 1'b0;
  logic       HRESET, HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [3:0] req_port;

  logic [1:0] addr_f, addr_r;
  logic       nop_f, nop_r, etf_f, etf_r;
  logic [3:0] g_f, g_r;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 HCLK = ~HCLK;

  nanosoc_arbiter_param #(.NUM_PORTS(N), .ARB_MODE(0), .EARLY_TERM_MAX(ETM)) u_fixed (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_f), .no_port(nop_f), .grant_onehot(g_f), .early_term_force(etf_f));

  nanosoc_arbiter_param #(.NUM_PORTS(N), .ARB_MODE(1), .EARLY_TERM_MAX(ETM)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_r), .no_port(nop_r), .grant_onehot(g_r), .early_term_force(etf_r));

  // Behavioural model: beats remaining in the held burst, early-term tally,
  // and per-mode (0 = fixed, 1 = round-robin) grant state.
  int m_cnt = 0, m_et = 0;
  bit m_hold = 0, m_force = 0;
  int m_addr[2] = '{0, 0};
  bit m_nop[2]  = '{1, 1};
  int m_rr[2]   = '{N - 1, N - 1};
  int mn_cnt, found, j;
  bit mn_hold, mn_force;
  bit [3:0] cand;

  function automatic int burst_len(input logic [2:0] b);
    if (b >= 3'd6) return 16;
    if (b >= 3'd4) return 8;
    if (b >= 3'd2) return 4;
    return 1;
  endfunction

  always @(posedge HCLK) begin
    if (HRESET) begin
      m_cnt = 0; m_hold = 0; m_et = 0; m_force = 0;
      for (int m = 0; m < 2; m++) begin
        m_addr[m] = 0; m_nop[m] = 1; m_rr[m] = N - 1;
      end
    end else if (HREADYM) begin
      mn_cnt = m_cnt; mn_hold = m_hold; mn_force = 0;
      if (!HSELM || HTRANSM == 2'b00) begin
        mn_cnt = 0; mn_hold = 0;
      end else if (HTRANSM == 2'b10) begin
        mn_cnt = burst_len(HBURSTM) - 1; mn_hold = (mn_cnt > 0);
      end else if (HTRANSM == 2'b11) begin
        mn_cnt = (m_cnt + 15) % 16;
        if (m_cnt == 1) mn_hold = 0;
      end
      if (m_et == ETM && HTRANSM == 2'b10) begin
        mn_hold = 0; mn_cnt = 0; mn_force = 1;
      end
      if (!mn_hold) m_et = 0;
      else if (m_hold && HTRANSM == 2'b10) m_et = m_et + 1;

      for (int m = 0; m < 2; m++) begin
        if (HMASTLOCKM || mn_hold) begin
          m_nop[m] = 0;
        end else begin
          cand = req_port;
          if (HSELM && HTRANSM != 2'b00) cand[m_addr[m]] = 1'b1;
          found = -1;
          for (int k = 0; k < N; k++) begin
            j = (m == 0) ? k : (m_rr[m] + 1 + k) % N;
            if (found < 0 && cand[j]) found = j;
          end
          if (found >= 0) begin
            m_addr[m] = found; m_nop[m] = 0; m_rr[m] = found;
          end else begin
            m_nop[m] = !HSELM;
          end
        end
      end
      m_cnt = mn_cnt; m_hold = mn_hold; m_force = mn_force;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("fixed.addr", 32'(addr_f), 32'(m_addr[0]));
      chk("fixed.no_port", 32'(nop_f), 32'(m_nop[0]));
      chk("fixed.grant", 32'(g_f), m_nop[0] ? 32'd0 : (32'd1 << m_addr[0]));
      chk("fixed.etf", 32'(etf_f), 32'(m_force));
      chk("rr.addr", 32'(addr_r), 32'(m_addr[1]));
      chk("rr.no_port", 32'(nop_r), 32'(m_nop[1]));
      chk("rr.grant", 32'(g_r), m_nop[1] ? 32'd0 : (32'd1 << m_addr[1]));
      chk("rr.etf", 32'(etf_r), 32'(m_force));
    end
  end

  task automatic drive(input bit rst, input bit rdy, input logic [3:0] req, input bit sel,
                       input logic [1:0] trans, input logic [2:0] burst, input bit lock);
    HRESET = rst; HREADYM = rdy; req_port = req; HSELM = sel;
    HTRANSM = trans; HBURSTM = burst; HMASTLOCKM = lock;
    @(posedge HCLK);
    #2;
  endtask

  initial begin
    // Reset held for two edges with all ports requesting
    drive(1, 1, 4'b1111, 0, 2'b00, 3'd0, 0);
    chk_en = 1'b1;
    drive(1, 1, 4'b1111, 0, 2'b00, 3'd0, 0);
    chk("rst.no_port", 32'(nop_f), 32'd1);
    chk("rst.addr", 32'(addr_r), 32'd0);
    chk("rst.grant", 32'(g_r), 32'd0);
    drive(0, 1, 4'b1111, 0, 2'b00, 3'd0, 0);
    chk("post_rst.addr_f", 32'(addr_f), 32'd0);
    chk("post_rst.grant_f", 32'(g_f), 32'b0001);
    chk("post_rst.grant_r", 32'(g_r), 32'b0001);

    // Fixed-mode INCR4 hold by port 2 against lower-numbered requesters
    drive(0, 1, 4'b0100, 0, 2'b00, 3'd0, 0);
    chk("burst.grant2", 32'(addr_f), 32'd2);
    drive(0, 1, 4'b0011, 1, 2'b10, 3'b011, 0);
    chk("burst.nonseq", 32'(addr_f), 32'd2);
    drive(0, 1, 4'b0011, 1, 2'b11, 3'b011, 0);
    chk("burst.seq1", 32'(addr_f), 32'd2);
    drive(0, 1, 4'b0011, 1, 2'b11, 3'b011, 0);
    chk("burst.seq2", 32'(addr_f), 32'd2);
    drive(0, 1, 4'b0011, 1, 2'b11, 3'b011, 0);
    chk("burst.release", 32'(addr_f), 32'd0);

    // Round-robin rotation from a fresh pointer
    drive(1, 1, 4'b0000, 0, 2'b00, 3'd0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 4'b1111, 1, 2'b10, 3'd0, 0);
      chk("rr.rotate", 32'(addr_r), 32'(i % 4));
      chk("rr.fixed_stays0", 32'(addr_f), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'b1001, 1, 2'b10, 3'd0, 0);
      chk("rr.alt", 32'(addr_r), (i % 2 == 0) ? 32'd3 : 32'd0);
    end

    // HREADYM stall freezes grant and pointer
    drive(0, 0, 4'b0010, 1, 2'b10, 3'd0, 0);
    chk("stall.1", 32'(addr_r), 32'd0);
    drive(0, 0, 4'b0100, 0, 2'b00, 3'd0, 0);
    chk("stall.2", 32'(addr_r), 32'd0);
    drive(0, 0, 4'b1000, 1, 2'b10, 3'd0, 0);
    chk("stall.3", 32'(addr_r), 32'd0);
    drive(0, 1, 4'b1000, 1, 2'b10, 3'd0, 0);
    chk("stall.resume", 32'(addr_r), 32'd3);

    // Early termination: one burst start then three terminating NONSEQs
    drive(1, 1, 4'b0000, 0, 2'b00, 3'd0, 0);
    drive(0, 1, 4'b0010, 0, 2'b00, 3'd0, 0);
    chk("et.grant1", 32'(addr_r), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'b0011, 1, 2'b10, 3'b101, 0);
      chk("et.hold", 32'(addr_f), 32'd1);
      chk("et.no_force", 32'(etf_f), 32'd0);
      drive(0, 1, 4'b0011, 1, 2'b11, 3'b101, 0);
    end
    drive(0, 1, 4'b0011, 1, 2'b10, 3'b101, 0);
    chk("et.force_f", 32'(etf_f), 32'd1);
    chk("et.force_r", 32'(etf_r), 32'd1);
    chk("et.port0_f", 32'(addr_f), 32'd0);
    chk("et.port0_r", 32'(addr_r), 32'd0);
    drive(0, 1, 4'b0000, 0, 2'b00, 3'd0, 0);
    chk("et.force_clear", 32'(etf_f), 32'd0);
    chk("et.no_port", 32'(nop_f), 32'd1);

    // Lock retention, then reset in the middle of a held burst
    drive(0, 1, 4'b1000, 0, 2'b00, 3'd0, 0);
    chk("lock.grant3", 32'(addr_r), 32'd3);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 4'b0001, 1, 2'b10, 3'd0, 1);
      chk("lock.keep_f", 32'(addr_f), 32'd3);
      chk("lock.keep_r", 32'(addr_r), 32'd3);
    end
    drive(0, 1, 4'b0001, 1, 2'b10, 3'b011, 0);
    drive(0, 1, 4'b0001, 1, 2'b11, 3'b011, 0);
    chk("lock.burst_hold", 32'(addr_f), 32'd3);
    drive(1, 1, 4'b0001, 1, 2'b11, 3'b011, 0);
    chk("midrst.no_port", 32'(nop_f), 32'd1);
    chk("midrst.grant", 32'(g_r), 32'd0);
    drive(0, 1, 4'b0001, 1, 2'b11, 3'b011, 0);
    chk("midrst.cleared", 32'(addr_f), 32'd0);
    chk("midrst.grant0", 32'(g_f), 32'b0001);

    // Randomized traffic checked cycle-by-cycle against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 200) == 0, ($urandom % 5) != 0, 4'($urandom), ($urandom % 8) != 0,
            2'($urandom), 3'($urandom), ($urandom % 12) == 0);
    end

    @(negedge HCLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
